// File: rtl/serial_parity_rx.sv
// Receive side of the XOR parity link: start, DATA_W data bits LSB first, parity, stop.
// Define SERIAL_PARITY_RX_ERRCNT_EN to add a saturating 16-bit err_count of errored frames.
//
// state  | meaning
// IDLE   | waiting for a valid 0 (start bit); valid 1s are line idle
// DATA   | shifting in DATA_W data bits, running XOR in acc
// PARITY | comparing the received parity bit against acc
// STOP   | sampling the stop bit, publishing the word and flags
module serial_parity_rx #(
  parameter int DATA_W     = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
`ifdef SERIAL_PARITY_RX_ERRCNT_EN
  ,
  output logic [15:0]       err_count
`endif
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              acc;
  logic              perr;
  logic [DATA_W:0]   shift_ext;

  // One bit wider than the word so the shift also works for DATA_W == 1.
  assign shift_ext = {bit_in, shreg};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      acc        <= 1'b0;
      perr       <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (bit_valid) begin
        case (state)
          IDLE: begin
            if (!bit_in) begin
              state   <= DATA;
              bit_cnt <= '0;
              acc     <= (PARITY_ODD != 0);
              busy    <= 1'b1;
            end
          end
          DATA: begin
            shreg   <= shift_ext[DATA_W:1];
            acc     <= acc ^ bit_in;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) state <= PARITY;
          end
          PARITY: begin
            perr  <= acc ^ bit_in;
            state <= STOP;
          end
          STOP: begin
            data_out   <= shreg;
            parity_err <= perr;
            frame_err  <= ~bit_in;
            data_valid <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef SERIAL_PARITY_RX_ERRCNT_EN
  // Counts frames, not errors: a frame with both flags set adds one.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
    end else if (bit_valid && state == STOP && (perr || !bit_in) && err_count != 16'hFFFF) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_serial_parity_rx.sv
// Directed bench for serial_parity_rx: an even-parity and an odd-parity instance share one bit stream.
module tb_serial_parity_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_in;
  logic       bit_valid;
  logic [7:0] dout_e, dout_o;
  logic       dv_e, dv_o, pe_e, pe_o, fe_e, fe_o, busy_e, busy_o;
`ifdef SERIAL_PARITY_RX_ERRCNT_EN
  logic [15:0] ec_e, ec_o;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int pulses_e = 0;
  int pulses_o = 0;
  int p0;

  always #5 clk = ~clk;

  serial_parity_rx #(.DATA_W(8), .PARITY_ODD(0)) dut_even (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .data_out(dout_e), .data_valid(dv_e), .parity_err(pe_e), .frame_err(fe_e), .busy(busy_e)
`ifdef SERIAL_PARITY_RX_ERRCNT_EN
    , .err_count(ec_e)
`endif
  );

  serial_parity_rx #(.DATA_W(8), .PARITY_ODD(1)) dut_odd (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .data_out(dout_o), .data_valid(dv_o), .parity_err(pe_o), .frame_err(fe_o), .busy(busy_o)
`ifdef SERIAL_PARITY_RX_ERRCNT_EN
    , .err_count(ec_o)
`endif
  );

  always @(posedge clk) begin
    if (dv_e) pulses_e++;
    if (dv_o) pulses_o++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int gap);
    repeat (gap) tick();
    bit_in    = b;
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
    bit_in    = 1'b1;
  endtask

  // Returns one step after the edge that samples the stop bit.
  task automatic send_frame(input logic [7:0] w, input logic par, input logic stp, input int gap);
    send_bit(1'b0, 0);
    for (int i = 0; i < 8; i++) send_bit(w[i], gap);
    send_bit(par, gap);
    send_bit(stp, gap);
  endtask

  initial begin
    rst = 1'b1; bit_in = 1'b1; bit_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    check("rst_dout", 32'(dout_e), 32'h0);
    check("rst_dv", 32'(dv_e), 32'h0);
    check("rst_busy", 32'(busy_e), 32'h0);
    check("rst_flags", 32'({pe_e, fe_e}), 32'h0);

    repeat (5) send_bit(1'b1, 0);
    tick();
    check("idle_pulses", 32'(pulses_e), 32'h0);
    check("idle_busy", 32'(busy_e), 32'h0);
    check("idle_dout", 32'(dout_e), 32'h0);

    // 0xA5, even parity bit 0, good stop
    p0 = pulses_e;
    send_frame(8'hA5, 1'b0, 1'b1, 0);
    check("a5_dv", 32'(dv_e), 32'h1);
    check("a5_busy", 32'(busy_e), 32'h0);
    check("a5_dout", 32'(dout_e), 32'hA5);
    check("a5_flags", 32'({pe_e, fe_e}), 32'h0);
    tick();
    check("a5_dv_fall", 32'(dv_e), 32'h0);
    check("a5_one_pulse", 32'(pulses_e - p0), 32'h1);

    // 0x07 with wrong parity bit
    send_frame(8'h07, 1'b0, 1'b1, 0);
    check("07_dv", 32'(dv_e), 32'h1);
    check("07_dout", 32'(dout_e), 32'h07);
    check("07_perr", 32'(pe_e), 32'h1);
    check("07_ferr", 32'(fe_e), 32'h0);
`ifdef SERIAL_PARITY_RX_ERRCNT_EN
    check("07_errcnt", 32'(ec_e), 32'h1);
`endif
    repeat (4) tick();
    check("07_hold", 32'(dout_e), 32'h07);
    check("07_hold_perr", 32'(pe_e), 32'h1);

    // 0x3C, good parity, bad stop, 3-cycle stalls between bits
    p0 = pulses_e;
    send_frame(8'h3C, 1'b0, 1'b0, 3);
    check("3c_dv", 32'(dv_e), 32'h1);
    check("3c_dout", 32'(dout_e), 32'h3C);
    check("3c_ferr", 32'(fe_e), 32'h1);
    check("3c_perr", 32'(pe_e), 32'h0);
`ifdef SERIAL_PARITY_RX_ERRCNT_EN
    check("3c_errcnt", 32'(ec_e), 32'h2);
`endif
    tick();
    check("3c_one_pulse", 32'(pulses_e - p0), 32'h1);

    // Abort after 4 data bits; rst wins over a coincident valid 0
    p0 = pulses_e;
    send_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
    check("abort_busy", 32'(busy_e), 32'h1);
    rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b1;
    tick();
    rst = 1'b0; bit_valid = 1'b0; bit_in = 1'b1;
    check("abort_busy_clr", 32'(busy_e), 32'h0);
    check("abort_dout_clr", 32'(dout_e), 32'h0);
    repeat (3) send_bit(1'b1, 0);
    check("abort_no_pulse", 32'(pulses_e - p0), 32'h0);
    check("abort_idle", 32'(busy_e), 32'h0);

    send_frame(8'h5A, 1'b0, 1'b1, 0);
    check("5a_dv", 32'(dv_e), 32'h1);
    check("5a_dout", 32'(dout_e), 32'h5A);
    check("5a_flags", 32'({pe_e, fe_e}), 32'h0);
`ifdef SERIAL_PARITY_RX_ERRCNT_EN
    check("5a_errcnt", 32'(ec_e), 32'h0);
`endif
    tick();
    check("5a_one_pulse", 32'(pulses_e - p0), 32'h1);

    // Odd parity: 0xA5 with parity 1, then 0x07 with parity 0, back to back
    p0 = pulses_o;
    send_frame(8'hA5, 1'b1, 1'b1, 0);
    check("odd_a5_dv", 32'(dv_o), 32'h1);
    check("odd_a5_dout", 32'(dout_o), 32'hA5);
    check("odd_a5_flags", 32'({pe_o, fe_o}), 32'h0);
    send_frame(8'h07, 1'b0, 1'b1, 0);
    check("odd_07_dv", 32'(dv_o), 32'h1);
    check("odd_07_dout", 32'(dout_o), 32'h07);
    check("odd_07_flags", 32'({pe_o, fe_o}), 32'h0);
    tick();
    check("odd_pulses", 32'(pulses_o - p0), 32'h2);
    check("odd_dv_fall", 32'(dv_o), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
